set_requester: RTL

Initiator-side controller for a K-way CLOCK-replacement cache set. It accepts CPU-side read and write requests on a valid/ready channel and sequences the set's enable/read/write strobes, including the set's multi-cycle miss/eviction write. It then returns one response per request on a valid/ready channel. It sits between the core load/store path and one set instance.

---
 rtl/set_requester_if.sv | 40 ++++
 rtl/set_requester.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/set_requester_if.sv
// rtl/set_requester_if.sv - request/response and set-strobe bundle for set_requester
interface set_requester_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 32
);
   // CPU-side request channel
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LINE_WIDTH-1:0] req_wdata;
   // CPU-side response channel
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_hit;
   logic                  resp_err;
   logic [LINE_WIDTH-1:0] resp_rdata;
   // Set-side strobes and returned status
   logic                  set_enable;
   logic                  set_read;
   logic                  set_write;
   logic [ADDR_WIDTH-1:0] set_addr;
   logic [LINE_WIDTH-1:0] set_val;
   logic                  set_hit;
   logic [LINE_WIDTH-1:0] set_out_val;

   // The requester itself: answers the CPU and drives the set
   modport master (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready, set_hit, set_out_val,
      output req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
             set_enable, set_read, set_write, set_addr, set_val
   );

   // The surroundings: the CPU load/store path plus the set instance
   modport slave (
      output req_valid, req_write, req_addr, req_wdata, resp_ready, set_hit, set_out_val,
      input  req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
             set_enable, set_read, set_write, set_addr, set_val
   );
endinterface

// File: rtl/set_requester.sv
// rtl/set_requester.sv - CLOCK-cache set initiator; optional SET_REQUESTER_STATS_EN adds hit/miss counters
module set_requester #(
   parameter int ADDR_WIDTH       = 8,
   parameter int LINE_WIDTH       = 32,
   parameter int K                = 2,
   parameter int MAX_WRITE_CYCLES = 2*K+2
) (
   input  logic            clock,
   input  logic            reset_n,
   set_requester_if.master bus
`ifdef SET_REQUESTER_STATS_EN
   ,
   output logic [15:0]     stat_hits,
   output logic [15:0]     stat_misses
`endif
);
   localparam int CW = $clog2(MAX_WRITE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WRITE_CYCLES);

   typedef enum logic [2:0] {
      IDLE, RD_ISSUE, RD_CAPTURE, WR_FIRST, WR_EVICT, RESP
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  hit_q, hit_d;
   logic                  err_q, err_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
   logic                  req_ready_c;
   logic                  resp_valid_c;
   logic                  en_c, rd_c, wr_c;

   // State and latched request/response registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Next state, strobes and response capture
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      hit_d        = hit_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      req_ready_c  = 1'b0;
      resp_valid_c = 1'b0;
      en_c         = 1'b0;
      rd_c         = 1'b0;
      wr_c         = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               state_d = bus.req_write ? WR_FIRST : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            en_c    = 1'b1;
            rd_c    = 1'b1;
            state_d = RD_CAPTURE;
         end
         RD_CAPTURE: begin
            hit_d   = bus.set_hit;
            rdata_d = bus.set_hit ? bus.set_out_val : '0;
            err_d   = 1'b0;
            state_d = RESP;
         end
         WR_FIRST: begin
            en_c    = 1'b1;
            wr_c    = 1'b1;
            cnt_d   = CNT_ONE;
            state_d = WR_EVICT;
         end
         WR_EVICT: begin
            // A hit on the first check means the line was already resident;
            // a later hit means the eviction walk placed the line.
            if (bus.set_hit) begin
               hit_d   = (cnt_q == CNT_ONE);
               rdata_d = '0;
               state_d = RESP;
            end else if (cnt_q < CNT_MAX) begin
               en_c  = 1'b1;
               wr_c  = 1'b1;
               cnt_d = cnt_q + CW'(1);
            end else begin
               hit_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid_c = 1'b1;
            if (bus.resp_ready) begin
               hit_d   = 1'b0;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // req_ready is gated by reset so nothing looks acceptable while held in reset
   assign bus.req_ready  = req_ready_c & reset_n;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_hit   = hit_q;
   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.set_enable = en_c;
   assign bus.set_read   = rd_c;
   assign bus.set_write  = wr_c;
   assign bus.set_addr   = (state_q == IDLE) ? '0 : addr_q;
   assign bus.set_val    = (state_q == IDLE) ? '0 : wdata_q;

`ifdef SET_REQUESTER_STATS_EN
   // Saturating hit/miss tally of completed, error-free responses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state_q == RESP && bus.resp_ready && !err_q) begin
         if (hit_q) begin
            if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
         end else begin
            if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
         end
      end
   end
`endif
endmodule
